// File: rtl/mux_scan_pkg.sv
// Shared constants and helpers for the 4:1 mux scan sequencer.
// FSM encodings, channel geometry and enabled-channel search functions.
package mux_scan_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DWELL = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  // Lowest set index of mask; 0 when mask is empty.
  function automatic logic [SEL_W-1:0] lowest_ch(input logic [NCH-1:0] mask);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // Lowest set index strictly above cur; returns cur when none is found.
  function automatic logic [SEL_W-1:0] next_ch(input logic [NCH-1:0] mask,
                                              input logic [SEL_W-1:0] cur);
    logic [SEL_W-1:0] r;
    r = cur;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Loadable dwell down-counter with zero flag (and one flag when
// MUX_SCAN_DBL_SAMPLE_EN is defined, for the penultimate-edge sample).
module mux_scan_dwell_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
`ifdef MUX_SCAN_DBL_SAMPLE_EN
  ,
  output logic             one
`endif
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority so a reload on the sample edge wins over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);
`ifdef MUX_SCAN_DBL_SAMPLE_EN
  assign one  = (cnt_q == CNT_W'(1));
`endif

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps s through enabled channels, samples y_in
// at each dwell end. Optional double-sample check: MUX_SCAN_DBL_SAMPLE_EN.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             y_in,
  output logic [SEL_W-1:0] s,
  output logic             busy,
  output logic             done,
  output logic [NCH-1:0]   snap,
  output logic             snap_valid
`ifdef MUX_SCAN_DBL_SAMPLE_EN
  ,
  output logic             mismatch
`endif
);

  generate
    if ((DWELL < 1) || (DWELL > 255)) begin : g_dwell_range
      $error("mux_scan_ctrl: DWELL out of range");
    end
    if ((64'd1 << CNT_W) <= 64'(DWELL)) begin : g_cnt_w_check
      $error("mux_scan_ctrl: CNT_W too narrow for DWELL");
    end
`ifdef MUX_SCAN_DBL_SAMPLE_EN
    if (DWELL < 2) begin : g_dbl_dwell_check
      $error("mux_scan_ctrl: double sampling needs DWELL >= 2");
    end
`endif
  endgenerate

  state_t           state_q;
  logic [NCH-1:0]   mask_q;
  logic [NCH-1:0]   cur_bit;
  logic [NCH-1:0]   remaining;
  logic             launch;
  logic             sample;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;

  assign launch    = (state_q == ST_IDLE) && start;
  assign sample    = (state_q == ST_DWELL) && cnt_zero;
  assign cur_bit   = {{(NCH-1){1'b0}}, 1'b1} << s;
  assign remaining = mask_q & ~cur_bit;

  // Reload at launch and at every sample edge that moves on to another channel.
  assign cnt_load = launch || (sample && (remaining != '0));
  assign cnt_dec  = (state_q == ST_DWELL) && !cnt_zero;

`ifdef MUX_SCAN_DBL_SAMPLE_EN
  logic cnt_one;
`endif

  mux_scan_dwell_cnt #(
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_W'(DWELL - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
`ifdef MUX_SCAN_DBL_SAMPLE_EN
    ,
    .one      (cnt_one)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      s          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      snap       <= '0;
      snap_valid <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mask_q     <= ch_mask;
            snap       <= '0;
            snap_valid <= 1'b0;
            if (ch_mask != '0) begin
              s       <= lowest_ch(ch_mask);
              busy    <= 1'b1;
              state_q <= ST_DWELL;
            end else begin
              // Empty mask: finish immediately, leaving s where it was.
              busy       <= 1'b0;
              done       <= 1'b1;
              snap_valid <= 1'b1;
              state_q    <= ST_FIN;
            end
          end
        end
        ST_DWELL: begin
          if (cnt_zero) begin
            snap[s] <= y_in;
            mask_q  <= remaining;
            if (remaining != '0) begin
              s <= next_ch(remaining, s);
            end else begin
              busy       <= 1'b0;
              done       <= 1'b1;
              snap_valid <= 1'b1;
              state_q    <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          done    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MUX_SCAN_DBL_SAMPLE_EN
  logic first_q;

  // Early sample on the penultimate edge, compared against the final one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q  <= 1'b0;
      mismatch <= 1'b0;
    end else if (launch) begin
      mismatch <= 1'b0;
    end else if ((state_q == ST_DWELL) && cnt_one) begin
      first_q <= y_in;
    end else if (sample && (y_in != first_q)) begin
      mismatch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed self-checking bench for mux_scan_ctrl (DWELL=4) with a behavioural
// 4:1 mux closing the loop from s back to y_in.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] ch_mask;
  logic [3:0] src;
  logic       y_in;
  logic [1:0] s;
  logic       busy;
  logic       done;
  logic [3:0] snap;
  logic       snap_valid;
`ifdef MUX_SCAN_DBL_SAMPLE_EN
  logic       mismatch;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign y_in = src[s];

  mux_scan_ctrl #(
    .DWELL (4),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ch_mask    (ch_mask),
    .y_in       (y_in),
    .s          (s),
    .busy       (busy),
    .done       (done),
    .snap       (snap),
    .snap_valid (snap_valid)
`ifdef MUX_SCAN_DBL_SAMPLE_EN
    ,
    .mismatch   (mismatch)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ch_mask = 4'b0000; src = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({s, busy, done, snap, snap_valid} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got s=%0d busy=%b done=%b snap=%b sv=%b, want all 0",
               s, busy, done, snap, snap_valid);
    end
`ifdef MUX_SCAN_DBL_SAMPLE_EN
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mismatch: got %b want 0", mismatch);
    end
`endif
    rst_n = 1'b1;
    tick();
    $display("reset: s=%0d busy=%b snap_valid=%b", s, busy, snap_valid);
  endtask

  task automatic test_full_scan();
    logic [1:0] exp_s;
    ch_mask = 4'b1111; src = 4'b1010; start = 1'b1;
    tick();
    start = 1'b0;
    for (int m = 0; m < 16; m++) begin
      exp_s = 2'(m / 4);
      n_checks++;
      if (s !== exp_s || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL full_scan_step%0d: got s=%0d busy=%b done=%b want s=%0d busy=1 done=0",
                 m, s, busy, done, exp_s);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || snap !== 4'b1010 || snap_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_scan_end: got done=%b busy=%b snap=%b sv=%b want 1 0 1010 1",
               done, busy, snap, snap_valid);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || snap_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_scan_pulse: got done=%b sv=%b want done=0 sv=1", done, snap_valid);
    end
    $display("full_scan: snap=%b", snap);
  endtask

  task automatic test_sparse_mask();
    logic [1:0] exp_s;
    ch_mask = 4'b0101; src = 4'b0101; start = 1'b1;
    tick();
    start = 1'b0;
    for (int m = 0; m < 8; m++) begin
      exp_s = (m < 4) ? 2'd0 : 2'd2;
      n_checks++;
      if (s !== exp_s || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL sparse_step%0d: got s=%0d busy=%b done=%b want s=%0d busy=1 done=0",
                 m, s, busy, done, exp_s);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || snap !== 4'b0101 || snap_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sparse_end: got done=%b busy=%b snap=%b sv=%b want 1 0 0101 1",
               done, busy, snap, snap_valid);
    end
    tick();
    $display("sparse_mask: snap=%b", snap);
  endtask

  task automatic test_empty_mask();
    ch_mask = 4'b0000; src = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || snap !== 4'b0000 || snap_valid !== 1'b1 || s !== 2'd2) begin
      n_fail++;
      $display("FAIL empty_mask: got done=%b busy=%b snap=%b sv=%b s=%0d want 1 0 0000 1 s=2",
               done, busy, snap, snap_valid, s);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || s !== 2'd2) begin
      n_fail++;
      $display("FAIL empty_mask_after: got done=%b s=%0d want done=0 s=2", done, s);
    end
    $display("empty_mask: snap=%b s=%0d", snap, s);
  endtask

  task automatic test_ignore_start();
    logic [1:0] exp_s;
    ch_mask = 4'b1111; src = 4'b0110; start = 1'b1;
    tick();
    start = 1'b0;
    for (int m = 0; m < 16; m++) begin
      exp_s = 2'(m / 4);
      n_checks++;
      if (s !== exp_s || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore_start_step%0d: got s=%0d busy=%b done=%b want s=%0d busy=1 done=0",
                 m, s, busy, done, exp_s);
      end
      if (m == 5) begin
        ch_mask = 4'b0001;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || snap !== 4'b0110) begin
      n_fail++;
      $display("FAIL ignore_start_end: got done=%b snap=%b want done=1 snap=0110", done, snap);
    end
    tick();
    $display("ignore_start: snap=%b", snap);
  endtask

  task automatic test_reset_mid_scan();
    logic [1:0] exp_s;
    ch_mask = 4'b1111; src = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s, busy, done, snap, snap_valid} !== 9'b0) begin
      n_fail++;
      $display("FAIL midscan_reset: got s=%0d busy=%b done=%b snap=%b sv=%b want all 0",
               s, busy, done, snap, snap_valid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    ch_mask = 4'b0011; src = 4'b0010; start = 1'b1;
    tick();
    start = 1'b0;
    for (int m = 0; m < 8; m++) begin
      exp_s = 2'(m / 4);
      n_checks++;
      if (s !== exp_s || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_step%0d: got s=%0d busy=%b done=%b want s=%0d busy=1 done=0",
                 m, s, busy, done, exp_s);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || snap !== 4'b0010 || snap_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_end: got done=%b snap=%b sv=%b want 1 0010 1", done, snap, snap_valid);
    end
    tick();
    $display("reset_mid_scan: rescan snap=%b", snap);
  endtask

  task automatic test_back_to_back();
    ch_mask = 4'b0001; src = 4'b0001; start = 1'b1;
    tick();
    repeat (4) tick();
    n_checks++;
    if (done !== 1'b1 || snap !== 4'b0001) begin
      n_fail++;
      $display("FAIL b2b_first_done: got done=%b snap=%b want 1 0001", done, snap);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || snap_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_fin_ignore: got done=%b busy=%b sv=%b want 0 0 1", done, busy, snap_valid);
    end
    tick();
    n_checks++;
    if (busy !== 1'b1 || snap_valid !== 1'b0 || snap !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_relaunch: got busy=%b sv=%b snap=%b want 1 0 0000", busy, snap_valid, snap);
    end
    start = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (done !== 1'b1 || snap !== 4'b0001) begin
      n_fail++;
      $display("FAIL b2b_second_done: got done=%b snap=%b want 1 0001", done, snap);
    end
    tick();
    $display("back_to_back: snap=%b", snap);
  endtask

`ifdef MUX_SCAN_DBL_SAMPLE_EN
  task automatic test_dbl_sample();
    ch_mask = 4'b0100; src = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    src = 4'b0100;
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL dbl_before: got mismatch=%b want 0", mismatch);
    end
    tick();
    n_checks++;
    if (mismatch !== 1'b1 || snap !== 4'b0100 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL dbl_detect: got mismatch=%b snap=%b done=%b want 1 0100 1", mismatch, snap, done);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL dbl_clear: got mismatch=%b want 0", mismatch);
    end
    repeat (4) tick();
    n_checks++;
    if (mismatch !== 1'b0 || done !== 1'b1 || snap !== 4'b0100) begin
      n_fail++;
      $display("FAIL dbl_stable: got mismatch=%b done=%b snap=%b want 0 1 0100", mismatch, done, snap);
    end
    tick();
    $display("dbl_sample: snap=%b mismatch=%b", snap, mismatch);
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_empty_mask();
    test_ignore_start();
    test_reset_mid_scan();
    test_back_to_back();
`ifdef MUX_SCAN_DBL_SAMPLE_EN
    test_dbl_sample();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Upstream sequencer for the 4:1 select mux (`mux41`).
- Drives the mux select `s[1:0]` through the enabled input channels, holding each for a programmable dwell time.
- Samples the returned mux output `y` at the end of each dwell and assembles a 4-bit snapshot of all enabled channels.
- Used to scan four single-bit sources through one mux, with a start/done handshake to the consuming logic.

Parameters:
- DWELL, default 4: cycles `s` is held per enabled channel, including the sample cycle; legal range 1..255 (2..255 with the optional feature).
- CNT_W, default 8: dwell counter width; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  scan request; sampled only in IDLE
- ch_mask  in  4  channel enable mask, bit n = mux input n; latched at accepted start
- y_in  in  1  output y of the downstream 4:1 mux
- s  out  2  mux select, registered
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at end of scan
- snap  out  4  captured y per channel; bit n = value sampled while s==n; disabled bits 0
- snap_valid  out  1  snap holds a complete scan result
- mismatch  out  1  present only with the optional feature

Behaviour:
- Reset: async assert, sync-free deassert inside block. s=0, busy=0, done=0, snap=0, snap_valid=0, state IDLE, counter 0.
- Reset mid-scan aborts the scan immediately. No done pulse, and the snapshot is lost.
- FSM states: IDLE, DWELL, FIN.
- IDLE:
  - s holds its last value.
  - On an edge E0 with start=1:
    - latch ch_mask into mask_q
    - clear snap and snap_valid
    - busy=1
    - counter=DWELL-1
  - If mask_q != 0: s = lowest set bit index, go to DWELL.
  - If mask_q == 0: go directly to FIN at E0.
- DWELL:
  - Counter decrements each edge.
  - At the edge where the counter reads 0:
    - snap[s] <= y_in
    - clear mask_q[s]
    - if remaining mask_q bits are set: s <= next higher set index, counter reloads DWELL-1
    - otherwise go to FIN
- FIN (one cycle): done=1, busy=0, snap_valid=1 from entry edge; next edge go to IDLE with done=0.
- Timing: with k enabled channels, the first select is valid from E0. Sample edges are E0+DWELL·j, for j=1..k. done is high during the cycle following E0+k·DWELL (k=0 gives done right after E0).
- s changes only on sample edges. It never selects a disabled channel during a scan.
- start while busy or in FIN is ignored, with no queuing. ch_mask changes after E0 are ignored.
- start held high re-launches a scan from the first IDLE edge after FIN.
- snap_valid stays 1 until the next accepted start or reset.

Optional Feature:
- Macro MUX_SCAN_DBL_SAMPLE_EN.
- Defined:
  - y_in is also sampled at the edge where the counter reads 1 (the penultimate dwell edge).
  - If the two samples differ, the sticky output mismatch is set. Snap still takes the final sample.
  - mismatch clears on accepted start or reset; reset value 0.
  - DWELL must be ≥2; DWELL=1 is a compile-time error via generate check.
- Undefined: the mismatch port and its logic are absent; DWELL=1 is legal.

Decomposition:
- Shared package/include `mux_scan_pkg`:
  - state encodings IDLE=2'd0, DWELL=2'd1, FIN=2'd2
  - NCH=4 and SEL_W=2 constants
  - a next-enabled-channel function (priority search above the current index)
- One natural sub-module, `mux_scan_dwell_cnt`: loadable down-counter with `zero` and `one` flags. The FSM and snapshot logic stay in the top.

Test Plan:
1. DWELL=4, ch_mask=4'b1111, start pulse; y_in is a combinational model of the mux with i0..i3=0,1,0,1 → s=0,1,2,3, each held 4 cycles; done 16 cycles after E0; snap=4'b1010; snap_valid=1; busy low with done.
2. ch_mask=4'b0101, i0=1, i2=1 → s visits only 0 then 2; done after 8 cycles; snap=4'b0101; s never equals 1 or 3 while busy.
3. ch_mask=4'b0000, start → done in the cycle after E0, snap=0, snap_valid=1, s unchanged.
4. Start mask 4'b1111; change ch_mask to 4'b0001 and pulse start at cycle 5 → both ignored; scan completes all 4 channels in 16 cycles.
5. rst_n low at cycle 6 of a scan → s, busy, done, snap and snap_valid go to 0 immediately; a new start after release scans normally.
6. With MUX_SCAN_DBL_SAMPLE_EN, DWELL=4, y_in toggles between the last two dwell edges of channel 2 → mismatch=1 and snap[2] takes the final value; the next start clears mismatch.
